// File: rtl/apb_ctrl_pkg.sv
// Shared types and helpers for the APB transfer controller.
// Holds the FSM state encoding and the length-code to write-strobe mapping.
package apb_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_e;

    localparam logic [5:0] LEN_BYTE = 6'b000001;
    localparam logic [5:0] LEN_HALF = 6'b000010;
    localparam logic [5:0] LEN_WORD = 6'b000100;

    // Unrecognised codes fall back to a single byte lane, like the upstream decoder.
    function automatic logic [3:0] len_to_strb(input logic [5:0] len);
        case (len)
            LEN_HALF: return 4'b0011;
            LEN_WORD: return 4'b1111;
            default:  return 4'b0001;
        endcase
    endfunction

endpackage

// File: rtl/apb_timeout_counter.sv
// Counts ACCESS-phase wait cycles and flags the cycle on which the limit is reached.
// A TIMEOUT_CYCLES of 0 disables the timeout entirely.
module apb_timeout_counter #(
    parameter int TIMEOUT_CYCLES = 256,
    parameter int CNT_W          = 9
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);

    localparam int              LIMIT_M1 = (TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1;
    localparam logic [CNT_W-1:0] LIMIT   = CNT_W'(TIMEOUT_CYCLES);

    logic [CNT_W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (enable_i && (count_q != LIMIT)) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // Asserted during the wait cycle whose increment would reach the limit.
    assign expired_o = (TIMEOUT_CYCLES != 0) && (count_q == CNT_W'(LIMIT_M1));

endmodule

// File: rtl/apb_transfer_ctrl.sv
// Runs one decoded bridge request as an APB4 SETUP/ACCESS transfer and returns
// read data and error status on a valid/ready response port.
module apb_transfer_ctrl
    import apb_ctrl_pkg::*;
#(
    parameter int ADDR_W         = 32,
    parameter int TIMEOUT_CYCLES = 256,
    parameter int CNT_W          = 9
) (
    input  logic              HCLK,
    input  logic              HRESET,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic              req_write,
    input  logic [31:0]       req_wdata,
    input  logic [5:0]        req_length,
    output logic              PSEL,
    output logic              PENABLE,
    output logic [ADDR_W-1:0] PADDR,
    output logic              PWRITE,
    output logic [31:0]       PWDATA,
    output logic [3:0]        PSTRB,
    input  logic [31:0]       PRDATA,
    input  logic              PREADY,
    input  logic              PSLVERR,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic              rsp_timeout
);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] paddr_q, paddr_d;
    logic              pwrite_q, pwrite_d;
    logic [31:0]       pwdata_q, pwdata_d;
    logic [3:0]        pstrb_q, pstrb_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              err_q, err_d;
    logic              timeout_q, timeout_d;
    logic              cnt_clear, cnt_en, cnt_expired;

    apb_timeout_counter #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
        .CNT_W         (CNT_W)
    ) u_timeout (
        .clk_i    (HCLK),
        .rst_i    (HRESET),
        .clear_i  (cnt_clear),
        .enable_i (cnt_en),
        .expired_o(cnt_expired)
    );

    always_comb begin
        state_d   = state_q;
        paddr_d   = paddr_q;
        pwrite_d  = pwrite_q;
        pwdata_d  = pwdata_q;
        pstrb_d   = pstrb_q;
        rdata_d   = rdata_q;
        err_d     = err_q;
        timeout_d = timeout_q;
        req_ready = 1'b0;
        PSEL      = 1'b0;
        PENABLE   = 1'b0;
        rsp_valid = 1'b0;
        cnt_clear = 1'b0;
        cnt_en    = 1'b0;
        case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                cnt_clear = 1'b1;
                if (req_valid) begin
                    paddr_d  = req_addr;
                    pwrite_d = req_write;
                    pwdata_d = req_wdata;
                    pstrb_d  = req_write ? len_to_strb(req_length) : 4'b0000;
                    state_d  = SETUP;
                end
            end
            SETUP: begin
                PSEL    = 1'b1;
                state_d = ACCESS;
            end
            ACCESS: begin
                PSEL    = 1'b1;
                PENABLE = 1'b1;
                // PREADY is checked first so a completion on the limit cycle wins.
                if (PREADY) begin
                    rdata_d   = pwrite_q ? 32'h0 : PRDATA;
                    err_d     = PSLVERR;
                    timeout_d = 1'b0;
                    state_d   = RESP;
                end else begin
                    cnt_en = 1'b1;
                    if (cnt_expired) begin
                        rdata_d   = 32'h0;
                        err_d     = 1'b1;
                        timeout_d = 1'b1;
                        state_d   = RESP;
                    end
                end
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state_q   <= IDLE;
            paddr_q   <= '0;
            pwrite_q  <= 1'b0;
            pwdata_q  <= '0;
            pstrb_q   <= '0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            paddr_q   <= paddr_d;
            pwrite_q  <= pwrite_d;
            pwdata_q  <= pwdata_d;
            pstrb_q   <= pstrb_d;
            rdata_q   <= rdata_d;
            err_q     <= err_d;
            timeout_q <= timeout_d;
        end
    end

    assign PADDR       = paddr_q;
    assign PWRITE      = pwrite_q;
    assign PWDATA      = pwdata_q;
    assign PSTRB       = pstrb_q;
    assign rsp_rdata   = rdata_q;
    assign rsp_err     = err_q;
    assign rsp_timeout = timeout_q;

endmodule

// File: tb/tb_apb_transfer_ctrl.sv
// Directed, table-driven bench for apb_transfer_ctrl with a 4-cycle PREADY timeout,
// plus hand-written sequences for mid-transfer reset and back-to-back requests.
module tb_apb_transfer_ctrl;

    logic        HCLK = 1'b0;
    logic        HRESET;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        req_write;
    logic [31:0] req_wdata;
    logic [5:0]  req_length;
    logic        PSEL, PENABLE, PWRITE;
    logic [31:0] PADDR, PWDATA;
    logic [3:0]  PSTRB;
    logic [31:0] PRDATA;
    logic        PREADY, PSLVERR;
    logic        rsp_valid, rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err, rsp_timeout;

    int testsRun = 0;
    int failCount = 0;

    localparam int TMO = 4;

    apb_transfer_ctrl #(
        .ADDR_W        (32),
        .TIMEOUT_CYCLES(TMO),
        .CNT_W         (3)
    ) dut (
        .HCLK       (HCLK),
        .HRESET     (HRESET),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_addr   (req_addr),
        .req_write  (req_write),
        .req_wdata  (req_wdata),
        .req_length (req_length),
        .PSEL       (PSEL),
        .PENABLE    (PENABLE),
        .PADDR      (PADDR),
        .PWRITE     (PWRITE),
        .PWDATA     (PWDATA),
        .PSTRB      (PSTRB),
        .PRDATA     (PRDATA),
        .PREADY     (PREADY),
        .PSLVERR    (PSLVERR),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err),
        .rsp_timeout(rsp_timeout)
    );

    always #5 HCLK = ~HCLK;

    typedef struct {
        logic        write;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [5:0]  length;
        int          waits;
        logic        slverr;
        logic [31:0] prdata;
        int          hold;
        logic [3:0]  expStrb;
        logic [31:0] expRdata;
        logic        expErr;
        logic        expTimeout;
    } vec_t;

    vec_t vecs[9];

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        testsRun++;
        if (act !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic checkBit(input string name, input logic act, input logic exp);
        testsRun++;
        if (act !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got %b, expected %b", name, act, exp);
        end
    endtask

    task automatic checkRsp(input string tag, input vec_t v);
        checkBit({tag, " PSEL"}, PSEL, 1'b0);
        checkBit({tag, " PENABLE"}, PENABLE, 1'b0);
        checkBit({tag, " rsp_valid"}, rsp_valid, 1'b1);
        checkBit({tag, " req_ready"}, req_ready, 1'b0);
        checkOutput({tag, " rsp_rdata"}, rsp_rdata, v.expRdata);
        checkBit({tag, " rsp_err"}, rsp_err, v.expErr);
        checkBit({tag, " rsp_timeout"}, rsp_timeout, v.expTimeout);
    endtask

    // Runs one vector from request acceptance through response handshake.
    task automatic applyStimulus(input int idx);
        vec_t  v;
        int    nAccess;
        string tag;
        v   = vecs[idx];
        tag = $sformatf("v%0d", idx);
        nAccess = (v.waits + 1 > TMO) ? TMO : v.waits + 1;

        @(negedge HCLK);
        checkBit({tag, " idle req_ready"}, req_ready, 1'b1);
        req_valid  = 1'b1;
        req_addr   = v.addr;
        req_write  = v.write;
        req_wdata  = v.wdata;
        req_length = v.length;
        @(posedge HCLK);
        @(negedge HCLK);
        req_valid = 1'b0;
        checkBit({tag, " setup PSEL"}, PSEL, 1'b1);
        checkBit({tag, " setup PENABLE"}, PENABLE, 1'b0);
        checkOutput({tag, " setup PADDR"}, PADDR, v.addr);
        checkBit({tag, " setup PWRITE"}, PWRITE, v.write);
        checkOutput({tag, " setup PSTRB"}, 32'(PSTRB), 32'(v.expStrb));
        if (v.write) checkOutput({tag, " setup PWDATA"}, PWDATA, v.wdata);

        for (int i = 0; i < nAccess; i++) begin
            @(negedge HCLK);
            PREADY  = (i == v.waits);
            PSLVERR = v.slverr;
            PRDATA  = v.prdata;
            checkBit($sformatf("%s access%0d PSEL", tag, i), PSEL, 1'b1);
            checkBit($sformatf("%s access%0d PENABLE", tag, i), PENABLE, 1'b1);
            checkOutput($sformatf("%s access%0d PADDR", tag, i), PADDR, v.addr);
            checkBit($sformatf("%s access%0d PWRITE", tag, i), PWRITE, v.write);
            checkBit($sformatf("%s access%0d req_ready", tag, i), req_ready, 1'b0);
        end

        @(negedge HCLK);
        PREADY  = 1'b0;
        PSLVERR = 1'b0;
        PRDATA  = 32'hBAD0BAD0;
        checkRsp({tag, " resp"}, v);
        for (int h = 0; h < v.hold; h++) begin
            @(negedge HCLK);
            checkRsp($sformatf("%s hold%0d", tag, h), v);
        end
        rsp_ready = 1'b1;
        @(posedge HCLK);
        @(negedge HCLK);
        rsp_ready = 1'b0;
        checkBit({tag, " done rsp_valid"}, rsp_valid, 1'b0);
        checkBit({tag, " done req_ready"}, req_ready, 1'b1);
    endtask

    initial begin
        // write addr wdata len waits slverr prdata hold | strb rdata err timeout
        vecs[0] = '{1'b1, 32'h10, 32'hDEADBEEF, 6'b000100, 0, 1'b0, 32'h0,        0, 4'b1111, 32'h0,        1'b0, 1'b0};
        vecs[1] = '{1'b0, 32'h20, 32'h0,        6'b000100, 3, 1'b0, 32'h12345678, 0, 4'b0000, 32'h12345678, 1'b0, 1'b0};
        vecs[2] = '{1'b1, 32'h30, 32'hFFFFFF5A, 6'b000001, 0, 1'b1, 32'h0,        5, 4'b0001, 32'h0,        1'b1, 1'b0};
        vecs[3] = '{1'b0, 32'h40, 32'h0,        6'b000100, 9, 1'b0, 32'hAAAA5555, 1, 4'b0000, 32'h0,        1'b1, 1'b1};
        vecs[4] = '{1'b1, 32'h44, 32'h11223344, 6'b000100, 3, 1'b0, 32'h0,        0, 4'b1111, 32'h0,        1'b0, 1'b0};
        vecs[5] = '{1'b1, 32'h50, 32'hCAFE1234, 6'b000010, 1, 1'b0, 32'h0,        0, 4'b0011, 32'h0,        1'b0, 1'b0};
        vecs[6] = '{1'b1, 32'h60, 32'h000000A5, 6'b000011, 0, 1'b0, 32'h0,        0, 4'b0001, 32'h0,        1'b0, 1'b0};
        vecs[7] = '{1'b0, 32'h64, 32'h0,        6'b000001, 2, 1'b1, 32'h00000055, 0, 4'b0000, 32'h00000055, 1'b1, 1'b0};
        vecs[8] = '{1'b1, 32'h68, 32'h87654321, 6'b000100, 0, 1'b0, 32'hFFFFFFFF, 0, 4'b1111, 32'h0,        1'b0, 1'b0};

        HRESET = 1'b1;
        req_valid = 1'b0; req_addr = '0; req_write = 1'b0; req_wdata = '0; req_length = '0;
        PRDATA = '0; PREADY = 1'b0; PSLVERR = 1'b0; rsp_ready = 1'b0;
        repeat (2) @(posedge HCLK);
        @(negedge HCLK);
        HRESET = 1'b0;
        checkBit("reset PSEL", PSEL, 1'b0);
        checkBit("reset PENABLE", PENABLE, 1'b0);
        checkOutput("reset PADDR", PADDR, 32'h0);
        checkOutput("reset PWDATA", PWDATA, 32'h0);
        checkOutput("reset PSTRB", 32'(PSTRB), 32'h0);
        checkBit("reset PWRITE", PWRITE, 1'b0);
        checkBit("reset rsp_valid", rsp_valid, 1'b0);
        checkOutput("reset rsp_rdata", rsp_rdata, 32'h0);
        checkBit("reset rsp_err", rsp_err, 1'b0);
        checkBit("reset req_ready", req_ready, 1'b1);

        for (int k = 0; k < 9; k++) applyStimulus(k);

        // Reset while waiting in ACCESS: bus drops, no response ever appears.
        @(negedge HCLK);
        req_valid = 1'b1; req_addr = 32'h80; req_write = 1'b0; req_length = 6'b000100;
        @(posedge HCLK);
        @(negedge HCLK);
        req_valid = 1'b0;
        @(negedge HCLK);
        checkBit("rst-mid PENABLE before", PENABLE, 1'b1);
        HRESET = 1'b1;
        @(posedge HCLK);
        @(negedge HCLK);
        HRESET = 1'b0;
        PREADY = 1'b1;
        checkBit("rst-mid PSEL", PSEL, 1'b0);
        checkBit("rst-mid PENABLE", PENABLE, 1'b0);
        checkBit("rst-mid rsp_valid", rsp_valid, 1'b0);
        checkBit("rst-mid req_ready", req_ready, 1'b1);
        checkOutput("rst-mid PADDR", PADDR, 32'h0);
        for (int c = 0; c < 4; c++) begin
            @(negedge HCLK);
            checkBit($sformatf("rst-mid quiet%0d rsp_valid", c), rsp_valid, 1'b0);
        end
        PREADY = 1'b0;
        applyStimulus(0);

        // Back-to-back: second request waits until response is consumed.
        @(negedge HCLK);
        req_valid = 1'b1; req_addr = 32'h70; req_write = 1'b1; req_wdata = 32'h01020304; req_length = 6'b000100;
        PREADY = 1'b1;
        @(posedge HCLK);
        @(negedge HCLK);
        req_addr = 32'h74; req_wdata = 32'h05060708; req_length = 6'b000010;
        checkBit("b2b setup req_ready", req_ready, 1'b0);
        checkOutput("b2b first PADDR", PADDR, 32'h70);
        @(negedge HCLK);
        checkBit("b2b access PENABLE", PENABLE, 1'b1);
        checkOutput("b2b access PADDR", PADDR, 32'h70);
        for (int c = 0; c < 2; c++) begin
            @(negedge HCLK);
            checkBit($sformatf("b2b resp%0d rsp_valid", c), rsp_valid, 1'b1);
            checkBit($sformatf("b2b resp%0d req_ready", c), req_ready, 1'b0);
            checkBit($sformatf("b2b resp%0d PSEL", c), PSEL, 1'b0);
        end
        rsp_ready = 1'b1;
        @(posedge HCLK);
        @(negedge HCLK);
        rsp_ready = 1'b0;
        checkBit("b2b idle req_ready", req_ready, 1'b1);
        checkBit("b2b idle PSEL", PSEL, 1'b0);
        checkOutput("b2b idle PADDR held", PADDR, 32'h70);
        @(posedge HCLK);
        @(negedge HCLK);
        req_valid = 1'b0;
        checkBit("b2b second PSEL", PSEL, 1'b1);
        checkBit("b2b second PENABLE", PENABLE, 1'b0);
        checkOutput("b2b second PADDR", PADDR, 32'h74);
        checkOutput("b2b second PSTRB", 32'(PSTRB), 32'h3);
        checkOutput("b2b second PWDATA", PWDATA, 32'h05060708);
        @(negedge HCLK);
        @(negedge HCLK);
        PREADY = 1'b0;
        checkBit("b2b second rsp_valid", rsp_valid, 1'b1);
        checkBit("b2b second rsp_err", rsp_err, 1'b0);
        rsp_ready = 1'b1;
        @(posedge HCLK);
        @(negedge HCLK);
        rsp_ready = 1'b0;
        checkBit("b2b end rsp_valid", rsp_valid, 1'b0);
        checkBit("b2b end req_ready", req_ready, 1'b1);

        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

endmodule

// File: doc/apb_transfer_ctrl.md
Name: apb_transfer_ctrl

Overview:
Downstream neighbour of the AHB-side data-length decoder in the AHB-to-APB bridge. It accepts one decoded transfer request (address, direction, length-shaped 32-bit write data, length code) and runs it as an APB4 transfer through the SETUP and ACCESS phases. It honours PREADY wait states, enforces a PREADY timeout, and returns read data and error status through a valid/ready response port to the bridge's AHB side.

Parameters:
ADDR_W, 32, APB address width
TIMEOUT_CYCLES, 256, max ACCESS-phase cycles waiting for PREADY; 0 disables the timeout
CNT_W, 9, timeout counter width; must satisfy 2**CNT_W > TIMEOUT_CYCLES

Ports:
HCLK  in  1  bridge clock
HRESET  in  1  synchronous active-high reset
req_valid  in  1  request present
req_ready  out  1  controller can accept a request
req_addr  in  ADDR_W  transfer address
req_write  in  1  1=write, 0=read
req_wdata  in  32  decoded write data (PWDATA from the length decoder)
req_length  in  6  SIGNAL_LENGTH code: 000001=byte, 000010=half, 000100=word
PSEL  out  1  APB select
PENABLE  out  1  APB enable
PADDR  out  ADDR_W  APB address
PWRITE  out  1  APB direction
PWDATA  out  32  APB write data
PSTRB  out  4  APB4 write strobes
PRDATA  in  32  APB read data
PREADY  in  1  APB ready
PSLVERR  in  1  APB slave error
rsp_valid  out  1  response present
rsp_ready  in  1  response consumed
rsp_rdata  out  32  read data (0 for writes and timeouts)
rsp_err  out  1  PSLVERR seen or timeout
rsp_timeout  out  1  transfer aborted by timeout

Behaviour:
- Single clock HCLK; reset is synchronous and active-high on HRESET. HRESET=1 at a rising edge forces state IDLE and clears all outputs and registers to 0: PSEL, PENABLE, PADDR, PWRITE, PWDATA, PSTRB, rsp_* = 0. In IDLE, req_ready=1 is combinational from the state.
- Reset mid-transfer: the APB bus is dropped on the next edge, and no response is produced for the aborted transfer.
- FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE: req_ready=1. On req_valid&&req_ready, register addr, write, wdata and strobe, then go to SETUP. req_ready=0 in all other states.
- SETUP (exactly 1 cycle): PSEL=1, PENABLE=0, PADDR/PWRITE/PWDATA/PSTRB valid. Next state is ACCESS.
- ACCESS: PSEL=1, PENABLE=1, all APB outputs held stable.
  - PREADY=1: capture rsp_rdata = PWRITE ? 0 : PRDATA, rsp_err = PSLVERR, rsp_timeout = 0; go to RESP.
  - PREADY=0: increment the timeout counter. When the count equals TIMEOUT_CYCLES (and TIMEOUT_CYCLES != 0), go to RESP with rsp_err=1, rsp_timeout=1, rsp_rdata=0.
  - PREADY=1 on the same cycle the timeout is reached: the PREADY completion wins.
- RESP: PSEL=0, PENABLE=0, rsp_valid=1. rsp fields are held until rsp_ready=1, then go to IDLE and clear rsp_valid.
- Latency: request accepted at edge 0; SETUP in cycle 1; ACCESS in cycle 2. With zero wait states, rsp_valid is asserted in cycle 3. Minimum request-to-request spacing is 4 cycles.
- PSTRB: 000001 -> 0001, 000010 -> 0011, 000100 -> 1111; any other code -> 0001, matching the decoder's default byte handling. Reads drive PSTRB=0000.
- PADDR, PWRITE, PWDATA and PSTRB hold their last values when PSEL=0; they are never X after reset.
- Timeout counter: cleared on entry to SETUP, saturates at TIMEOUT_CYCLES.
- Unknown FSM encoding returns to IDLE.

Decomposition:
- Package apb_ctrl_pkg holds:
  - the state enum;
  - localparams LEN_BYTE=6'b000001, LEN_HALF=6'b000010, LEN_WORD=6'b000100;
  - function len_to_strb(6-bit) -> 4-bit.
- Sub-module apb_timeout_counter (clear, enable, expired output, parameterised by TIMEOUT_CYCLES/CNT_W) is instantiated once in apb_transfer_ctrl.

Test Plan:
- Word write, addr 0x10, wdata 0xDEADBEEF, length 000100, PREADY tied 1 -> SETUP in cycle 1 (PSEL=1, PENABLE=0), ACCESS in cycle 2, PSTRB=1111, rsp_valid in cycle 3, rsp_err=0, rsp_rdata=0.
- Read addr 0x20 with PREADY low for 3 ACCESS cycles, PRDATA=0x12345678 -> PADDR/PWRITE stable for all 4 ACCESS cycles; rsp_rdata=0x12345678; req_ready=0 throughout.
- Byte write with wdata 0xFFFFFF5A, length 000001, PSLVERR=1 on completion -> PSTRB=0001, rsp_err=1, rsp_timeout=0. Holding rsp_ready=0 for 5 cycles keeps rsp_valid and its fields stable.
- TIMEOUT_CYCLES=4, PREADY held 0 -> after 4 ACCESS cycles PSEL/PENABLE drop; rsp_err=1, rsp_timeout=1, rsp_rdata=0. A second run with PREADY=1 on the 4th cycle completes normally.
- HRESET pulsed during ACCESS -> next edge PSEL=PENABLE=0, rsp_valid=0, req_ready=1; no response is emitted afterwards. A new request then completes normally.
- Illegal length 000011 write -> PSTRB=0001. A back-to-back request with req_valid held high is accepted only after rsp_ready returns the FSM to IDLE.
